// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/forwarding unit:
// memory-wait FSM states, forwarding select codes and control bundles.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_LAST = 2'd2
    } mem_state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;
    localparam logic [1:0] FWD_IMM = 2'b11;

    typedef struct packed {
        logic pc_wr;
        logic d_wr;
        logic e_wr;
        logic m_wr;
        logic d_flush;
        logic e_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN    = '{pc_wr: 1'b1, d_wr: 1'b1, e_wr: 1'b1, m_wr: 1'b1,
                                           d_flush: 1'b0, e_flush: 1'b0};
    localparam pipe_ctrl_t CTRL_FREEZE = '{pc_wr: 1'b0, d_wr: 1'b0, e_wr: 1'b0, m_wr: 1'b0,
                                           d_flush: 1'b0, e_flush: 1'b0};
    localparam pipe_ctrl_t CTRL_BRANCH = '{pc_wr: 1'b1, d_wr: 1'b1, e_wr: 1'b1, m_wr: 1'b1,
                                           d_flush: 1'b1, e_flush: 1'b1};
    localparam pipe_ctrl_t CTRL_LU     = '{pc_wr: 1'b0, d_wr: 1'b0, e_wr: 1'b1, m_wr: 1'b1,
                                           d_flush: 1'b0, e_flush: 1'b1};

endpackage

// File: rtl/hazard_fwd_unit_fwd_sel.sv
// One ALU operand's forwarding select: M result beats W result,
// r0 never forwarded, loads in M not forwarded (data not ready yet).
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned RA_W = 5
) (
    input  logic [RA_W-1:0] src,
    input  logic            imm_sel,
    input  logic [RA_W-1:0] m_rw,
    input  logic            m_regwr,
    input  logic            m_memrd,
    input  logic [RA_W-1:0] w_rw,
    input  logic            w_regwr,
    output logic [1:0]      sel
);

    logic hit_m;
    logic hit_w;

    always_comb begin
        hit_m = m_regwr && !m_memrd && (m_rw != '0) && (m_rw == src);
        hit_w = w_regwr && (w_rw != '0) && (w_rw == src);
        sel   = FWD_REG;
        if (imm_sel) begin
            sel = FWD_IMM;
        end else if (hit_m) begin
            sel = FWD_MEM;
        end else if (hit_w) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard unit for the 5-stage pipeline: forwarding selects, load-use stall,
// taken-branch flush, multi-cycle load freeze and a saturating stall counter.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int unsigned RA_W     = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  D_Rs,
    input  logic [RA_W-1:0]  D_Rt,
    input  logic             D_UseRs,
    input  logic             D_UseRt,
    input  logic [RA_W-1:0]  E_Rs,
    input  logic [RA_W-1:0]  E_Rt,
    input  logic             E_ALUSrc,
    input  logic [RA_W-1:0]  E_Rw,
    input  logic             E_RegWr,
    input  logic             E_MemRd,
    input  logic             E_BrTaken,
    input  logic [RA_W-1:0]  M_Rw,
    input  logic             M_RegWr,
    input  logic             M_MemRd,
    input  logic [RA_W-1:0]  W_Rw,
    input  logic             W_RegWr,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             PC_Wr,
    output logic             D_Wr,
    output logic             E_Wr,
    output logic             M_Wr,
    output logic             D_Flush,
    output logic             E_Flush,
    output logic [CNT_W-1:0] StallCnt
);

    localparam int unsigned CB         = $clog2(LOAD_LAT + 1);
    localparam bit          MULTI      = (LOAD_LAT > 1);
    localparam logic [CB-1:0] CNT_INIT = MULTI ? CB'(LOAD_LAT - 2) : '0;

    mem_state_t  state;
    mem_state_t  state_nx;
    logic [CB-1:0] cnt;
    logic [CB-1:0] cnt_nx;
    logic        freeze;
    logic        load_use;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    pipe_ctrl_t  ctrl;
    logic [CNT_W-1:0] stall_cnt;

    fwd_sel #(.RA_W(RA_W)) u_fwd_a (
        .src     (E_Rs),
        .imm_sel (1'b0),
        .m_rw    (M_Rw),
        .m_regwr (M_RegWr),
        .m_memrd (M_MemRd),
        .w_rw    (W_Rw),
        .w_regwr (W_RegWr),
        .sel     (sel_a)
    );

    fwd_sel #(.RA_W(RA_W)) u_fwd_b (
        .src     (E_Rt),
        .imm_sel (E_ALUSrc),
        .m_rw    (M_Rw),
        .m_regwr (M_RegWr),
        .m_memrd (M_MemRd),
        .w_rw    (W_Rw),
        .w_regwr (W_RegWr),
        .sel     (sel_b)
    );

    // Freeze covers the load's first LOAD_LAT-1 cycles in M; MEM_LAST lets it
    // advance and deliberately ignores M_MemRd so the same load is not re-armed.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        freeze   = 1'b0;
        unique case (state)
            RUN: begin
                if (M_MemRd && MULTI) begin
                    freeze   = 1'b1;
                    cnt_nx   = CNT_INIT;
                    state_nx = (LOAD_LAT == 2) ? MEM_LAST : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                freeze = 1'b1;
                cnt_nx = cnt - 1'b1;
                if (cnt == CB'(1)) begin
                    state_nx = MEM_LAST;
                end
            end
            MEM_LAST: begin
                state_nx = RUN;
            end
            default: begin
                state_nx = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        load_use = E_MemRd && E_RegWr && (E_Rw != '0) &&
                   ((D_UseRs && (D_Rs == E_Rw)) || (D_UseRt && (D_Rt == E_Rw)));
        ctrl = CTRL_RUN;
        if (rst) begin
            ctrl = CTRL_RUN;
        end else if (freeze) begin
            ctrl = CTRL_FREEZE;
        end else if (E_BrTaken) begin
            ctrl = CTRL_BRANCH;
        end else if (load_use) begin
            ctrl = CTRL_LU;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!ctrl.pc_wr && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign ALUSrcA  = rst ? FWD_REG : sel_a;
    assign ALUSrcB  = rst ? FWD_REG : sel_b;
    assign PC_Wr    = ctrl.pc_wr;
    assign D_Wr     = ctrl.d_wr;
    assign E_Wr     = ctrl.e_wr;
    assign M_Wr     = ctrl.m_wr;
    assign D_Flush  = ctrl.d_flush;
    assign E_Flush  = ctrl.e_flush;
    assign StallCnt = stall_cnt;

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised hazard unit for the 5-stage pipeline. It generates the ALU forwarding selects for the execute stage, with r0 exclusion and load-aware M-stage forwarding. It also detects load-use hazards and flushes on taken branches. A state machine freezes the pipeline for multi-cycle data-memory loads, and a saturating counter records stall cycles. It sits beside the pipeline registers and drives their write-enables and flushes.

## Interface
Parameters:
- RA_W, 5: register-address width.
- LOAD_LAT, 1: cycles a load occupies M (legal 1..8; 1 = no freeze).
- CNT_W, 16: stall-counter width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-high.
- D_Rs, D_Rt  in  RA_W  decode-stage sources; D_UseRs, D_UseRt  in  1  source actually read.
- E_Rs, E_Rt  in  RA_W  execute-stage sources; E_ALUSrc  in  1  operand B = immediate.
- E_Rw  in  RA_W; E_RegWr, E_MemRd, E_BrTaken  in  1  execute destination / write / load / branch resolved taken.
- M_Rw  in  RA_W; M_RegWr, M_MemRd  in  1  memory-stage destination / write / load.
- W_Rw  in  RA_W; W_RegWr  in  1  write-back destination / write.
- ALUSrcA, ALUSrcB  out  2  forwarding selects: 00 regfile, 01 M result, 10 W result, 11 immediate (B only).
- PC_Wr, D_Wr, E_Wr, M_Wr  out  1  PC and IF/ID, ID/EX, EX/MEM register enables.
- D_Flush, E_Flush  out  1  clear IF/ID, ID/EX to bubble.
- StallCnt  out  CNT_W  cycles with PC_Wr=0.

## Operation
- Forwarding (combinational):
  - MA = M_RegWr & !M_MemRd & M_Rw!=0 & M_Rw==E_Rs.
  - WA = W_RegWr & W_Rw!=0 & W_Rw==E_Rs.
  - ALUSrcA = MA ? 01 : WA ? 10 : 00.
  - ALUSrcB = E_ALUSrc ? 11 : same rule on E_Rt.
  - M beats W (youngest value).
- Load-use: LU = E_MemRd & E_RegWr & E_Rw!=0 & ((D_UseRs & D_Rs==E_Rw) | (D_UseRt & D_Rt==E_Rw)). Response: PC_Wr=0, D_Wr=0, E_Flush=1 for one cycle. The dependant then receives the load data from W via 10.
- Branch: E_BrTaken → D_Flush=1, E_Flush=1, PC_Wr=1.
- Memory-wait FSM, states RUN, MEM_WAIT, MEM_LAST; down-counter cnt of width clog2(LOAD_LAT+1). FREEZE drives PC_Wr=D_Wr=E_Wr=M_Wr=0 with both flushes 0.
  - RUN: if M_MemRd & LOAD_LAT>1, assert FREEZE and set cnt←LOAD_LAT-2. Next state is MEM_LAST if LOAD_LAT==2, else MEM_WAIT.
  - MEM_WAIT: assert FREEZE, cnt←cnt-1. Go to MEM_LAST when cnt==1.
  - MEM_LAST: no freeze; M_MemRd is ignored this cycle. Next state RUN.
  - Net effect: a load in M freezes LOAD_LAT-1 cycles and advances on its LOAD_LAT-th cycle.
- Priority: rst > FREEZE > branch > load-use.
  - A branch or LU arriving during FREEZE is held; it is re-evaluated when the freeze releases (E and D are frozen).
  - Branch and LU in the same cycle: branch only; no LU stall.
- Defaults (no event): all enables 1, flushes 0.
- StallCnt increments each cycle PC_Wr==0 and saturates at all-ones.

## Timing
- Forwarding, LU and branch outputs are combinational, valid in the same cycle as their inputs.
- FSM state, cnt and StallCnt update on the rising clk edge.
- While rst is high (asynchronous):
  - state=RUN, cnt=0, StallCnt=0.
  - Outputs forced: ALUSrcA=ALUSrcB=00, PC_Wr=D_Wr=E_Wr=M_Wr=1, D_Flush=E_Flush=0.
- Reset asserted mid-freeze aborts the wait at once. After release, the first edge evaluates from RUN.
- LOAD_LAT=1: the FSM never leaves RUN.
- Back-to-back loads: the second load reaches M only after MEM_LAST, then freezes from RUN again.

## Structure
- Package hazard_pkg holds:
  - state encoding: RUN=0, MEM_WAIT=1, MEM_LAST=2;
  - forwarding constants: FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10, FWD_IMM=2'b11.
- Sub-module fwd_sel: one operand's comparator and priority mux, parametrised by RA_W. It is instantiated twice; the B instance takes E_ALUSrc as its immediate override.

## Test plan
- M_RegWr=1, M_Rw=3, W_RegWr=1, W_Rw=3, E_Rs=3, E_Rt=3, E_ALUSrc=0 → ALUSrcA=01, ALUSrcB=01. With E_ALUSrc=1 → ALUSrcB=11. With M_Rw=W_Rw=0 → both 00.
- E_MemRd=E_RegWr=1, E_Rw=5, D_Rt=5, D_UseRt=1 → one cycle of PC_Wr=0, D_Wr=0, E_Flush=1; StallCnt 0→1. Next cycle M_MemRd=1, E_Rt=5, W forwarding path → ALUSrcB=10 one cycle later.
- LOAD_LAT=4, M_MemRd rises → FREEZE for exactly 3 cycles (StallCnt +3), MEM_LAST on the 4th with all enables 1, then RUN.
- LOAD_LAT=3, E_BrTaken=1 during FREEZE → no flush until release. On the release cycle D_Flush=E_Flush=1. Branch together with LU → flushes only, PC_Wr=1.
- rst pulsed in MEM_WAIT → outputs go to reset values without a clock edge and StallCnt=0. After release, FSM in RUN.
- CNT_W=4, 20 stall cycles → StallCnt saturates at 15.
